// File: rtl/fp8_pkg.sv
// Shared FP8 definitions for the stream accumulator: encodings of the
// special values, field positions and the accumulator state encoding.
// Format: 1 sign, 3 exponent (bias 3), 4 mantissa. Exponent 0 is zero
// (no subnormals) and exponent 7 is Inf (mantissa 0) or NaN.
package fp8_pkg;

   localparam logic [7:0] FP8_ZERO    = 8'h00;
   localparam logic [7:0] FP8_POS_INF = 8'h70;
   localparam logic [7:0] FP8_NEG_INF = 8'hF0;
   localparam logic [7:0] FP8_QNAN    = 8'h78;

   localparam int SIGN_BIT = 7;
   localparam int EXP_MSB  = 6;
   localparam int EXP_LSB  = 4;
   localparam int MAN_MSB  = 3;
   localparam int MAN_LSB  = 0;

   localparam logic [2:0] EXP_SPECIAL = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

endpackage

// File: rtl/adder_fp8.sv
// Combinational FP8 adder, round-to-nearest-even.
// NaN inputs and Inf-Inf give the canonical NaN 8'h78, overflow gives
// signed Inf, and results below the smallest normal flush to signed zero.
// IMPL_TYPE only selects how the leading-zero count is built; every
// setting produces the same result.
module adder_fp8
   import fp8_pkg::*;
#(
   parameter int IMPL_TYPE = 0
) (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] y
);

   logic       a_sign, b_sign;
   logic [2:0] a_exp, b_exp;
   logic [3:0] a_man, b_man;
   logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic       swap, eff_sub, big_sign, sticky;
   logic [2:0] big_exp, small_exp, diff;
   logic [3:0] big_man, small_man;
   logic [8:0] big_sig, small_full, small_sh, raw;
   logic [2:0] lz;

   // Field decode, magnitude ordering, alignment and raw add/subtract.
   always_comb begin
      a_sign = a[SIGN_BIT];
      b_sign = b[SIGN_BIT];
      a_exp  = a[EXP_MSB:EXP_LSB];
      b_exp  = b[EXP_MSB:EXP_LSB];
      a_man  = a[MAN_MSB:MAN_LSB];
      b_man  = b[MAN_MSB:MAN_LSB];
      a_nan  = (a_exp == EXP_SPECIAL) && (a_man != 4'd0);
      b_nan  = (b_exp == EXP_SPECIAL) && (b_man != 4'd0);
      a_inf  = (a_exp == EXP_SPECIAL) && (a_man == 4'd0);
      b_inf  = (b_exp == EXP_SPECIAL) && (b_man == 4'd0);
      a_zero = (a_exp == 3'd0);
      b_zero = (b_exp == 3'd0);

      // Larger magnitude goes first so the subtraction never goes negative.
      swap      = {b_exp, b_man} > {a_exp, a_man};
      big_sign  = swap ? b_sign : a_sign;
      big_exp   = swap ? b_exp : a_exp;
      big_man   = swap ? b_man : a_man;
      small_exp = swap ? a_exp : b_exp;
      small_man = swap ? a_man : b_man;
      eff_sub   = a_sign ^ b_sign;
      diff      = big_exp - small_exp;

      // Significands carry a hidden one plus three guard bits.
      big_sig    = {1'b0, 1'b1, big_man, 3'b000};
      small_full = {1'b0, 1'b1, small_man, 3'b000};
      small_sh   = small_full >> diff;
      sticky     = |(small_full & ((9'd1 << diff) - 9'd1));
      small_sh   = small_sh | {8'd0, sticky};

      raw = eff_sub ? (big_sig - small_sh) : (big_sig + small_sh);
   end

   // Leading-zero count of raw[7:0], used to renormalise after cancellation.
   generate
      if (IMPL_TYPE == 0) begin : g_lzc_prio
         always_comb begin
            casez (raw[7:0])
               8'b1???????: lz = 3'd0;
               8'b01??????: lz = 3'd1;
               8'b001?????: lz = 3'd2;
               8'b0001????: lz = 3'd3;
               8'b00001???: lz = 3'd4;
               8'b000001??: lz = 3'd5;
               8'b0000001?: lz = 3'd6;
               8'b00000001: lz = 3'd7;
               default:     lz = 3'd0;
            endcase
         end
      end else begin : g_lzc_scan
         always_comb begin
            lz = 3'd0;
            for (int i = 0; i < 8; i++) begin
               if (raw[i]) lz = 3'(7 - i);
            end
         end
      end
   endgenerate

   logic [7:0]        norm;
   logic signed [4:0] exp_n;
   logic              round_up;
   logic [5:0]        sig_r;
   logic [3:0]        man_r;

   // Special-value handling, normalisation, rounding and range check.
   always_comb begin
      y        = FP8_ZERO;
      norm     = 8'd0;
      exp_n    = 5'sd0;
      round_up = 1'b0;
      sig_r    = 6'd0;
      man_r    = 4'd0;
      if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
         y = FP8_QNAN;
      end else if (a_inf) begin
         y = a;
      end else if (b_inf) begin
         y = b;
      end else if (a_zero && b_zero) begin
         // Two zeros give -0 only when both are negative.
         y = {a_sign & b_sign, 7'd0};
      end else if (a_zero) begin
         y = b;
      end else if (b_zero) begin
         y = a;
      end else if (raw == 9'd0) begin
         y = FP8_ZERO;
      end else begin
         if (raw[8]) begin
            norm  = raw[8:1] | {7'd0, raw[0]};
            exp_n = $signed({2'b00, big_exp}) + 5'sd1;
         end else begin
            norm  = raw[7:0] << lz;
            exp_n = $signed({2'b00, big_exp}) - $signed({2'b00, lz});
         end
         round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
         sig_r    = {1'b0, norm[7:3]} + {5'd0, round_up};
         if (sig_r[5]) begin
            exp_n = exp_n + 5'sd1;
            man_r = 4'd0;
         end else begin
            man_r = sig_r[3:0];
         end
         if (exp_n < 5'sd1) begin
            y = {big_sign, 7'd0};
         end else if (exp_n >= 5'sd7) begin
            y = big_sign ? FP8_NEG_INF : FP8_POS_INF;
         end else begin
            y = {big_sign, exp_n[2:0], man_r};
         end
      end
   end

endmodule

// File: rtl/fp8_stream_accumulator.sv
// Packet-wise FP8 reduction: sums every operand of an in_last-delimited
// packet left to right through one adder in a feedback loop, then holds
// {sum, beat count} on the output until the consumer takes it.
// Handshake: a beat moves on a port in any cycle where valid and ready are
// both high at the rising edge; valid never waits for ready, and data stays
// stable while valid is high and ready is low. in_ready is a register and
// never depends combinationally on out_ready.
module fp8_stream_accumulator
   import fp8_pkg::*;
#(
   parameter int IMPL_TYPE = 0,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [7:0]       out_data,
   output logic [CNT_W-1:0] out_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic [7:0]       acc;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       sum;
   logic             accept;
   logic [CNT_W-1:0] cnt_inc;

   adder_fp8 #(
      .IMPL_TYPE(IMPL_TYPE)
   ) u_adder (
      .a(acc),
      .b(in_data),
      .y(sum)
   );

   assign accept  = in_valid & in_ready;
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

   // Packet FSM: accumulate beats, present the result, release on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         acc       <= FP8_ZERO;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= FP8_ZERO;
         out_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (in_last) begin
                     out_data  <= in_data;
                     out_count <= CNT_ONE;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     state     <= S_OUT;
                  end else begin
                     // First operand is loaded as-is so -0 and NaN payloads
                     // are not disturbed by an add to zero.
                     acc   <= in_data;
                     cnt   <= CNT_ONE;
                     state <= S_ACC;
                  end
               end
            end
            S_ACC: begin
               in_ready <= 1'b1;
               if (accept) begin
                  if (in_last) begin
                     out_data  <= sum;
                     out_count <= cnt_inc;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     state     <= S_OUT;
                  end else begin
                     acc <= sum;
                     cnt <= cnt_inc;
                  end
               end
            end
            S_OUT: begin
               // The handshake cycle itself is the single input bubble.
               in_ready <= out_ready;
               if (out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= FP8_ZERO;
                  cnt       <= '0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp8_stream_accumulator.sv
// Bench for fp8_stream_accumulator: a table of packets with hand-computed
// sums, followed by hand-written backpressure, reset and saturation runs.
module tb_fp8_stream_accumulator;
   import fp8_pkg::*;

   localparam int CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [7:0]       out_data;
   logic [CNT_W-1:0] out_count;

   int n_cmp = 0;
   int n_bad = 0;

   fp8_stream_accumulator #(
      .IMPL_TYPE(0),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_count(out_count)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string      name;
      int         n;
      logic [31:0] d;      // beat i in d[8*i +: 8]
      int         gap;     // idle cycles between beats
      logic [7:0] exp_data;
      logic [7:0] exp_count;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one beat: wait (bounded) for in_ready, present it across one edge.
   task automatic drive_beat(input logic [7:0] d, input logic last);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: got in_ready=0 expected 1");
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'hFF;   // junk while idle must be ignored
      in_last  = 1'b1;
   endtask

   // Called #1 after the edge that took the last beat, with out_ready high.
   task automatic check_result(input string tag, input logic [7:0] ed, input logic [7:0] ec);
      check({tag, "_valid"}, 8'(out_valid), 8'd1);
      check({tag, "_data"}, out_data, ed);
      check({tag, "_count"}, out_count, ec);
      check({tag, "_ready_low"}, 8'(in_ready), 8'd0);
      @(posedge clk); #1;
      check({tag, "_valid_drop"}, 8'(out_valid), 8'd0);
      check({tag, "_ready_back"}, 8'(in_ready), 8'd1);
   endtask

   initial begin
      vecs[0]  = '{"single_38",     1, 32'h00000038, 0, 8'h38, 8'd1};
      vecs[1]  = '{"three_ones",    3, 32'h00303030, 0, 8'h48, 8'd3};
      vecs[2]  = '{"overflow",      2, 32'h00006060, 0, 8'h70, 8'd2};
      vecs[3]  = '{"acc_cleared",   1, 32'h00000030, 0, 8'h30, 8'd1};
      vecs[4]  = '{"nan_prop",      3, 32'h00307930, 0, 8'h78, 8'd3};
      vecs[5]  = '{"cancel_zero",   2, 32'h0000B030, 0, 8'h00, 8'd2};
      vecs[6]  = '{"mixed_bubbles", 2, 32'h00003438, 2, 8'h46, 8'd2};
      vecs[7]  = '{"inf_minus_inf", 2, 32'h0000F070, 0, 8'h78, 8'd2};
      vecs[8]  = '{"sub_renorm",    2, 32'h0000B840, 0, 8'h20, 8'd2};
      vecs[9]  = '{"round_even",    2, 32'h0000103F, 0, 8'h42, 8'd2};
      vecs[10] = '{"underflow_neg", 2, 32'h00001098, 0, 8'h80, 8'd2};
      vecs[11] = '{"neg_zeros",     2, 32'h00008080, 0, 8'h80, 8'd2};
      vecs[12] = '{"left_to_right", 3, 32'h00E06060, 0, 8'h70, 8'd3};
      vecs[13] = '{"round_to_inf",  2, 32'h0000106F, 0, 8'h70, 8'd2};
      vecs[14] = '{"four_gapped",   4, 32'h30303030, 1, 8'h50, 8'd4};

      // reset
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 8'(in_ready), 8'd0);
      check("rst_out_valid", 8'(out_valid), 8'd0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_count", out_count, 8'd0);
      check("rst_state", 8'(dut.state), 8'(S_IDLE));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", 8'(in_ready), 8'd1);

      // table-driven packets
      for (int v = 0; v < 15; v++) begin
         for (int i = 0; i < vecs[v].n; i++) begin
            drive_beat(vecs[v].d[8*i +: 8], (i == vecs[v].n - 1));
            if (i != vecs[v].n - 1) begin
               check({vecs[v].name, "_early_valid"}, 8'(out_valid), 8'd0);
               repeat (vecs[v].gap) begin
                  @(posedge clk); #1;
               end
            end
         end
         check_result(vecs[v].name, vecs[v].exp_data, vecs[v].exp_count);
      end

      // intermediate sum, then reset mid-packet
      drive_beat(8'h30, 1'b0);
      drive_beat(8'h30, 1'b0);
      check("mid_acc", dut.acc, 8'h40);
      check("mid_cnt", dut.cnt, 8'd2);
      #2 rst_n = 1'b0;
      #1;
      check("arst_acc", dut.acc, 8'h00);
      check("arst_in_ready", 8'(in_ready), 8'd0);
      check("arst_out_valid", 8'(out_valid), 8'd0);
      check("arst_state", 8'(dut.state), 8'(S_IDLE));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_out_valid_after", 8'(out_valid), 8'd0);
      drive_beat(8'h40, 1'b1);
      check_result("after_rst", 8'h40, 8'd1);

      // backpressure: result held, input stalled, one bubble on release
      out_ready = 1'b0;
      drive_beat(8'h38, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h30;
      in_last  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         check("bp_in_ready", 8'(in_ready), 8'd0);
         check("bp_valid", 8'(out_valid), 8'd1);
         check("bp_data", out_data, 8'h38);
         check("bp_count", out_count, 8'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", 8'(out_valid), 8'd0);
      check("bp_release_ready", 8'(in_ready), 8'd1);
      check("bp_release_data", out_data, 8'h38);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_result("bp_next", 8'h30, 8'd1);

      // reset while a result is pending: it is dropped
      out_ready = 1'b0;
      drive_beat(8'h48, 1'b1);
      check("pend_valid", 8'(out_valid), 8'd1);
      #2 rst_n = 1'b0;
      #1;
      check("pend_rst_valid", 8'(out_valid), 8'd0);
      check("pend_rst_data", out_data, 8'h00);
      check("pend_rst_count", out_count, 8'd0);
      @(negedge clk) begin
         rst_n     = 1'b1;
         out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("pend_after_valid", 8'(out_valid), 8'd0);
      check("pend_after_ready", 8'(in_ready), 8'd1);

      // counter saturation: 261 beats, sum 1.0 + zeros + 1.0
      drive_beat(8'h30, 1'b0);
      for (int i = 0; i < 259; i++) drive_beat(8'h00, 1'b0);
      check("sat_cnt", dut.cnt, 8'd255);
      drive_beat(8'h30, 1'b1);
      check_result("sat", 8'h40, 8'd255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
